// File: rtl/ft_pkg.sv
`default_nettype none
// ==== ft_pkg: shared types and default widths for the ft_* fault-tolerance blocks | Rev 1.0 ====
package ft_pkg;

    localparam int FT_ADDR_WIDTH = 5;
    localparam int FT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_PC    = 3'd3,
        ST_DONE  = 3'd4
    } ft_restore_state_e;

endpackage : ft_pkg
`default_nettype wire

// File: rtl/ft_restore.sv
`default_nettype none
// ==== ft_restore: rebuilds core GPRs and PC from the shadow copy after a lockstep halt | Rev 1.0 ====
module ft_restore
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
    parameter int DATA_WIDTH = FT_DATA_WIDTH,
    parameter bit SKIP_X0    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  halted_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] sgpr_raddr_o,
    input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
    input  logic [DATA_WIDTH-1:0] spc_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    input  logic                  rf_gnt_i,
    output logic                  pc_set_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    input  logic                  pc_gnt_i
);

    localparam logic [ADDR_WIDTH-1:0] c_FIRST_IDX = ADDR_WIDTH'(SKIP_X0);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX  = '1;

    ft_restore_state_e       r_state;
    ft_restore_state_e       w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [ADDR_WIDTH-1:0]   w_idx_nxt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   w_data_nxt;
    logic [DATA_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   w_pc_nxt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_data  <= '0;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Abort wins over every transition; data already written is left in place.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_pc_nxt    = r_pc;
        if (abort_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i && halted_i) begin
                        w_state_nxt = ST_READ;
                        w_idx_nxt   = c_FIRST_IDX;
                        w_pc_nxt    = spc_i;
                    end
                end
                ST_READ: begin
                    w_data_nxt  = sgpr_rdata_i;
                    w_state_nxt = ST_WRITE;
                end
                ST_WRITE: begin
                    if (rf_gnt_i) begin
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt = ST_PC;
                        end else begin
                            w_idx_nxt   = r_idx + ADDR_WIDTH'(1);
                            w_state_nxt = ST_READ;
                        end
                    end
                end
                ST_PC: begin
                    if (pc_gnt_i) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode state and registers only, keeping grants off any output path.
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);
    assign rf_we_o      = (r_state == ST_WRITE);
    assign pc_set_o     = (r_state == ST_PC);
    assign sgpr_raddr_o = r_idx;
    assign rf_waddr_o   = r_idx;
    assign rf_wdata_o   = r_data;
    assign pc_o         = r_pc;

endmodule : ft_restore
`default_nettype wire
